// File: rtl/galaga_shot_ctrl_pkg.sv
// Shared encodings for the Galaga player-side blocks.
// Covers the controller state codes and the one-hot column codes.
package galaga_shot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FLY  = 2'b01,
    ST_HIT  = 2'b10,
    ST_MISS = 2'b11
  } shot_state_t;

  localparam logic [2:0] COL_L    = 3'b100;
  localparam logic [2:0] COL_C    = 3'b010;
  localparam logic [2:0] COL_R    = 3'b001;
  localparam logic [2:0] COL_NONE = 3'b000;

  // The ship FSM should only ever present one column; anything else is treated as "no position".
  function automatic logic col_valid(input logic [2:0] col);
    return (col == COL_L) || (col == COL_C) || (col == COL_R);
  endfunction

endpackage

// File: rtl/galaga_shot_ctrl_edge_rise.sv
// Rising-edge detector for an already-synchronous button level.
// Also usable for LEFT/RIGHT conditioning ahead of the ship FSM.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/galaga_shot_ctrl.sv
// Player-shot controller: launches one bullet from the ship column, steps it up at a
// prescaled rate and resolves it against the enemy row as a one-cycle HIT or MISS pulse.
module galaga_shot_ctrl
  import galaga_shot_ctrl_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fire,
  input  logic                    l,
  input  logic                    c,
  input  logic                    r,
  input  logic [2:0]              enemy,
  output logic                    shot_act,
  output logic [2:0]              shot_col,
  output logic [$clog2(ROWS)-1:0] shot_row,
  output logic                    hit,
  output logic [2:0]              hit_col,
  output logic                    miss,
  output logic [1:0]              sp
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  shot_state_t   state;
  logic [TW-1:0] tick;
  logic          fire_rise;
  logic [2:0]    pos;
  logic          last_tick;
  logic          top_row;

  edge_rise u_fire_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (fire),
    .rise (fire_rise)
  );

  assign pos       = {l, c, r};
  assign last_tick = (tick == TW'(TICK_DIV - 1));
  assign top_row   = (shot_row == RW'(ROWS - 1));
  assign sp        = state;

  // Pulses default low each cycle; the column is latched at launch so ship moves never steer it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tick     <= '0;
      shot_act <= 1'b0;
      shot_col <= COL_NONE;
      shot_row <= '0;
      hit      <= 1'b0;
      hit_col  <= COL_NONE;
      miss     <= 1'b0;
    end else begin
      hit     <= 1'b0;
      miss    <= 1'b0;
      hit_col <= COL_NONE;
      case (state)
        ST_IDLE: begin
          if (fire_rise && col_valid(pos)) begin
            state    <= ST_FLY;
            shot_act <= 1'b1;
            shot_col <= pos;
            shot_row <= '0;
            tick     <= '0;
          end
        end
        ST_FLY: begin
          if (last_tick) begin
            tick <= '0;
            if (top_row) begin
              shot_act <= 1'b0;
              shot_col <= COL_NONE;
              shot_row <= '0;
              // Enemy mask is only looked at on this terminal edge.
              if ((shot_col & enemy) != 3'b000) begin
                state   <= ST_HIT;
                hit     <= 1'b1;
                hit_col <= shot_col;
              end else begin
                state <= ST_MISS;
                miss  <= 1'b1;
              end
            end else begin
              shot_row <= shot_row + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_HIT, ST_MISS: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_galaga_shot_ctrl.sv
// Self-checking bench for galaga_shot_ctrl: directed scenarios plus random play,
// compared each cycle against a shot-age reference model.
module tb_galaga_shot_ctrl;

  localparam int ROWS     = 4;
  localparam int TICK_DIV = 4;
  localparam int RW       = $clog2(ROWS);
  localparam int FLIGHT   = ROWS * TICK_DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          fire;
  logic          l, c, r;
  logic [2:0]    enemy;
  logic          shot_act;
  logic [2:0]    shot_col;
  logic [RW-1:0] shot_row;
  logic          hit;
  logic [2:0]    hit_col;
  logic          miss;
  logic [1:0]    sp;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 flying, 2 hit pulse, 3 miss pulse; age counts clocks since launch.
  int         mMode;
  int         mAge;
  logic [2:0] mCol;
  logic       mPrevFire;

  galaga_shot_ctrl #(.ROWS(ROWS), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .fire     (fire),
    .l        (l),
    .c        (c),
    .r        (r),
    .enemy    (enemy),
    .shot_act (shot_act),
    .shot_col (shot_col),
    .shot_row (shot_row),
    .hit      (hit),
    .hit_col  (hit_col),
    .miss     (miss),
    .sp       (sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic flying;
    flying = (mMode == 1);
    chk("sp",       8'(sp),       8'(mMode));
    chk("shot_act", 8'(shot_act), 8'(flying));
    chk("shot_col", 8'(shot_col), flying ? 8'(mCol) : 8'h0);
    chk("shot_row", 8'(shot_row), flying ? 8'(mAge / TICK_DIV) : 8'h0);
    chk("hit",      8'(hit),      8'(mMode == 2));
    chk("hit_col",  8'(hit_col),  (mMode == 2) ? 8'(mCol) : 8'h0);
    chk("miss",     8'(miss),     8'(mMode == 3));
  endtask

  function automatic int onesOf(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic modelStep();
    logic rise;
    rise      = fire & ~mPrevFire;
    mPrevFire = fire;
    case (mMode)
      0: if (rise && onesOf({l, c, r}) == 1) begin
           mMode = 1;
           mAge  = 0;
           mCol  = {l, c, r};
         end
      1: if (mAge == FLIGHT - 1) mMode = ((mCol & enemy) != 3'b000) ? 2 : 3;
         else                    mAge++;
      default: mMode = 0;
    endcase
  endtask

  task automatic applyStimulus(input logic f, input logic [2:0] pos, input logic [2:0] en);
    @(negedge clk);
    fire = f;
    {l, c, r} = pos;
    enemy = en;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runFor(input int n, input logic f, input logic [2:0] pos, input logic [2:0] en);
    for (int i = 0; i < n; i++) applyStimulus(f, pos, en);
  endtask

  // Reset lands mid-cycle so outputs must clear without waiting for a clock edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst  = 1'b1;
    fire = 1'b0;
    #1;
    mMode     = 0;
    mAge      = 0;
    mCol      = 3'b000;
    mPrevFire = 1'b0;
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    fire  = 1'b0;
    {l, c, r} = 3'b000;
    enemy = 3'b000;
    mMode = 0; mAge = 0; mCol = 3'b000; mPrevFire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] launch from centre onto an enemy");
    runFor(2, 1'b0, 3'b010, 3'b010);
    runFor(20, 1'b1, 3'b010, 3'b010);

    $display("[TB] launch from left into an empty column");
    runFor(2, 1'b0, 3'b100, 3'b001);
    runFor(20, 1'b1, 3'b100, 3'b001);

    $display("[TB] held button and refire while flying");
    runFor(2, 1'b0, 3'b010, 3'b111);
    runFor(40, 1'b1, 3'b010, 3'b111);
    runFor(2, 1'b0, 3'b001, 3'b000);
    runFor(1, 1'b1, 3'b001, 3'b000);
    runFor(3, 1'b0, 3'b001, 3'b000);
    runFor(2, 1'b1, 3'b010, 3'b000);
    runFor(16, 1'b0, 3'b100, 3'b000);
    runFor(3, 1'b1, 3'b100, 3'b100);
    runFor(18, 1'b0, 3'b100, 3'b100);

    $display("[TB] ship moves during flight");
    runFor(1, 1'b1, 3'b001, 3'b101);
    runFor(4, 1'b0, 3'b001, 3'b101);
    runFor(16, 1'b0, 3'b100, 3'b101);

    $display("[TB] invalid positions and reset in flight");
    runFor(1, 1'b1, 3'b000, 3'b111);
    runFor(2, 1'b0, 3'b000, 3'b111);
    runFor(1, 1'b1, 3'b110, 3'b111);
    runFor(2, 1'b0, 3'b110, 3'b111);
    runFor(1, 1'b1, 3'b111, 3'b111);
    runFor(2, 1'b0, 3'b010, 3'b111);
    runFor(8, 1'b1, 3'b010, 3'b111);
    doReset();
    runFor(20, 1'b0, 3'b010, 3'b111);

    $display("[TB] random play");
    for (int i = 0; i < 900; i++) begin
      logic [2:0] pos;
      logic [2:0] en;
      case ($urandom_range(0, 4))
        0:       pos = 3'b100;
        1:       pos = 3'b010;
        2:       pos = 3'b001;
        default: pos = 3'($urandom_range(0, 7));
      endcase
      en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 249) == 0) doReset();
      else applyStimulus(1'($urandom_range(0, 1)), pos, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
